// File: rtl/complex_mult_param.sv
// Sequential complex multiplier: one shared N x N shift-add signed multiplier forms four partial products.
// Optional COMPLEX_MULT_PARAM_ACC_EN adds an acc port and G guard bits so results can accumulate into out.
module complex_mult_param #(
  parameter int N = 4,
  parameter int G = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*N-1:0]         a,
  input  logic [2*N-1:0]         b,
`ifdef COMPLEX_MULT_PARAM_ACC_EN
  input  logic                   acc,
  output logic [2*(2*N+1+G)-1:0] out,
`else
  output logic [2*(2*N+1)-1:0]   out,
`endif
  output logic                   ready,
  output logic                   valid
);

`ifdef COMPLEX_MULT_PARAM_ACC_EN
  localparam int P = 2*N + 1 + G;
`else
  localparam int P = 2*N + 1;
`endif
  localparam int CW = $clog2(N);

  if (N < 2 || N > 16 || G < 0) begin : g_bad_param
    $error("complex_mult_param: N must be 2..16 and G non-negative");
  end

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t          state;
  logic [1:0]      k;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  a_q, b_q;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  prod;
  logic [P-1:0]    re_s, im_s;
  logic [P-1:0]    out_re, out_im;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
  logic            acc_q;
`endif

  // Operand pair for the next product: taken from the live inputs at accept, from the held copy afterwards.
  // k=0 ar*br, k=1 ai*bi, k=2 ar*bi, k=3 ai*br.
  logic [2*N-1:0]  src_a, src_b;
  logic [1:0]      nk;
  logic [N-1:0]    x_sel, y_sel;
  logic [P-1:0]    prod_ext;
  logic            last_bit;

  always_comb begin
    if (state == IDLE) begin
      src_a = a;
      src_b = b;
      nk    = 2'd0;
    end else begin
      src_a = a_q;
      src_b = b_q;
      nk    = k + 2'd1;
    end
    x_sel = nk[0]           ? src_a[N-1:0] : src_a[2*N-1:N];
    y_sel = (nk[0] ^ nk[1]) ? src_b[N-1:0] : src_b[2*N-1:N];
  end

  assign prod_ext = {{(P-2*N){prod[2*N-1]}}, prod};
  assign last_bit = (cnt == CW'(N-1));
  assign out      = {out_re, out_im};

  // NOTE: every state element uses <= so all updates see pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= 2'd0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      re_s   <= '0;
      im_s   <= '0;
      out_re <= '0;
      out_im <= '0;
      ready  <= 1'b1;
      valid  <= 1'b0;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
      acc_q  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
            acc_q  <= acc;
`endif
            re_s   <= '0;
            im_s   <= '0;
            k      <= 2'd0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= {{N{x_sel[N-1]}}, x_sel};
            mplier <= y_sel;
            ready  <= 1'b0;
            state  <= MUL;
          end
        end
        MUL: begin
          // The multiplier's MSB carries weight -2^(N-1), so its partial product is subtracted.
          if (mplier[0])
            prod <= last_bit ? prod - mcand : prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last_bit) begin
            cnt   <= '0;
            state <= ACC;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        ACC: begin
          case (k)
            2'd0:    re_s <= re_s + prod_ext;
            2'd1:    re_s <= re_s - prod_ext;
            default: im_s <= im_s + prod_ext;
          endcase
          if (k == 2'd3) begin
            state <= DONE;
          end else begin
            k      <= k + 2'd1;
            prod   <= '0;
            mcand  <= {{N{x_sel[N-1]}}, x_sel};
            mplier <= y_sel;
            state  <= MUL;
          end
        end
        DONE: begin
`ifdef COMPLEX_MULT_PARAM_ACC_EN
          out_re <= acc_q ? out_re + re_s : re_s;
          out_im <= acc_q ? out_im + im_s : im_s;
`else
          out_re <= re_s;
          out_im <= im_s;
`endif
          k      <= 2'd0;
          valid  <= 1'b1;
          ready  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mult_param.sv
// Scoreboard bench for complex_mult_param (N=4); covers the COMPLEX_MULT_PARAM_ACC_EN build when that macro is defined.
module tb_complex_mult_param;

  localparam int N   = 4;
  localparam int G   = 4;
  localparam int LAT = 4*(N+1) + 1;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
  localparam int P = 2*N + 1 + G;
`else
  localparam int P = 2*N + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] a, b;
  logic [2*P-1:0] out;
  logic           ready, valid;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
  logic           acc;
`endif

  complex_mult_param #(.N(N), .G(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef COMPLEX_MULT_PARAM_ACC_EN
    .acc   (acc),
`endif
    .out   (out),
    .ready (ready),
    .valid (valid)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [2*P-1:0] exp_q[$];
  logic [P-1:0]   mod_re = '0;
  logic [P-1:0]   mod_im = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  // Reference model: signed products in int arithmetic, then wrapped to P bits.
  task automatic push_exp(input logic [2*N-1:0] ta, input logic [2*N-1:0] tb_v, input bit tacc);
    int ar, ai, br, bi, re, im;
    ar = int'($signed(ta[2*N-1:N]));
    ai = int'($signed(ta[N-1:0]));
    br = int'($signed(tb_v[2*N-1:N]));
    bi = int'($signed(tb_v[N-1:0]));
    re = ar*br - ai*bi;
    im = ar*bi + ai*br;
    if (tacc) begin
      mod_re = mod_re + P'(re);
      mod_im = mod_im + P'(im);
    end else begin
      mod_re = P'(re);
      mod_im = P'(im);
    end
    exp_q.push_back({mod_re, mod_im});
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_valid", 64'(valid), 64'd0);
      else check("out", 64'(out), 64'(exp_q.pop_front()));
    end
  end

  // Counts falling edges until valid is seen, starting from cyc0.
  task automatic wait_valid(input int cyc0, output int cyc);
    cyc = cyc0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) break;
      if (cyc >= 200) begin
        check("valid_timeout", 64'(cyc), 64'(LAT));
        break;
      end
    end
  endtask

  task automatic run_op(input logic [2*N-1:0] ta, input logic [2*N-1:0] tb_v,
                        input bit tacc, input bit poke);
    int cyc;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
    acc = tacc;
    push_exp(ta, tb_v, tacc);
`else
    push_exp(ta, tb_v, 1'b0);
`endif
    @(negedge clk);
    start = 1'b0;
    a = 2*N'($urandom);
    b = 2*N'($urandom);
    check("ready_low", 64'(ready), 64'd0);
    cyc = 0;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 5;
    end
    wait_valid(cyc, cyc);
    check("latency", 64'(cyc), 64'(LAT));
    check("ready_high", 64'(ready), 64'd1);
    @(negedge clk);
    check("valid_pulse", 64'(valid), 64'd0);
    check("out_hold", 64'(out), 64'({mod_re, mod_im}));
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
    acc = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out", 64'(out), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'd1);

    // Directed cases: nominal, -2^(N-1) corners, mixed signs; one with a start poked mid-operation.
    run_op(8'h67, 8'h53, 1'b0, 1'b0);
    run_op(8'h88, 8'h88, 1'b0, 1'b0);
    run_op(8'h78, 8'h78, 1'b0, 1'b1);
    run_op(8'h87, 8'h78, 1'b0, 1'b0);
    run_op(8'hF1, 8'h1F, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), i[0]);

    // start held high across DONE: the second acceptance waits for ready=1 at an edge.
    @(negedge clk);
    a = 8'h35;
    b = 8'hC2;
    start = 1'b1;
`ifdef COMPLEX_MULT_PARAM_ACC_EN
    acc = 1'b0;
`endif
    push_exp(8'h35, 8'hC2, 1'b0);
    push_exp(8'h35, 8'hC2, 1'b0);
    wait_valid(-1, cyc);
    check("b2b_lat1", 64'(cyc), 64'(LAT));
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", 64'(ready), 64'd0);
    wait_valid(0, cyc);
    check("b2b_lat2", 64'(cyc), 64'(LAT));
    @(negedge clk);
    check("b2b_pulse", 64'(valid), 64'd0);

    // Abort: start poked while busy, reset at cycle 10 with start high.
    @(negedge clk);
    a = 8'h67;
    b = 8'h53;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    mod_re = '0;
    mod_im = '0;
    check("abort_out", 64'(out), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_valid", 64'(valid), 64'd0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
    check("abort_ready_idle", 64'(ready), 64'd1);

`ifdef COMPLEX_MULT_PARAM_ACC_EN
    run_op(8'h67, 8'h53, 1'b0, 1'b0);
    run_op(8'h67, 8'h53, 1'b1, 1'b0);
    check("acc_sum", 64'(out), 64'({P'(18), P'(106)}));
    for (int i = 0; i < 34; i++)
      run_op(8'h88, 8'h88, 1'b1, 1'b0);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complex_mult_param.md
COMPLEX_MULT_PARAM -- requirements
Module: complex_mult_param

Interface
REQ-001 Parameter N, default 4: width of each signed two's-complement real and imaginary component; legal range 2..16.
REQ-002 Parameter G, default 4: accumulator guard bits; used only when COMPLEX_MULT_PARAM_ACC_EN is defined.
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: request a new operation; sampled only while ready=1.
REQ-006 Port a  input  2N: operand A; a[2N-1:N] real, a[N-1:0] imaginary.
REQ-007 Port b  input  2N: operand B; same packing as a.
REQ-008 Port acc  input  1: present only with COMPLEX_MULT_PARAM_ACC_EN; 1 = add result to held out, 0 = overwrite.
REQ-009 Port out  output  2P: {re, im}, each P bits signed; P = 2N+1, or 2N+1+G with the macro.
REQ-010 Port ready  output  1: high while idle and able to accept start.
REQ-011 Port valid  output  1: one-cycle pulse when out takes a new value.

Function
REQ-012 Computes re = ar*br - ai*bi, im = ar*bi + ai*br, all operands signed.
REQ-013 Uses one shared N x N sequential shift-add signed multiplier, one iteration per cycle; no parallel multipliers.
REQ-014 FSM states: IDLE, MUL, ACC, DONE; IDLE is the only state with ready=1.
REQ-015 IDLE: on start=1, registers a, b (and acc) on the same edge, clears partial sums, goes to MUL with product index k=0.
REQ-016 MUL: N cycles per product, then ACC; product order k=0 ar*br, k=1 ai*bi, k=2 ar*bi, k=3 ai*br.
REQ-017 ACC: one cycle; adds product (k=0,2,3) or subtracts (k=1) into the re (k<2) or im (k>=2) partial sum; k<3 -> MUL with k+1, k=3 -> DONE.
REQ-018 DONE: one cycle; loads out, pulses valid, returns to IDLE.
REQ-019 Latency: ready falls the cycle after start is sampled; valid and ready rise exactly 4(N+1)+1 cycles after the sampling edge (21 for N=4).
REQ-020 start while ready=0 is ignored; no queuing.
REQ-021 Operand changes after sampling do not affect the running operation.
REQ-022 Without the macro, P = 2N+1 holds every result exactly, including the -2^(N-1) corners; no overflow possible.
REQ-023 out holds its value between operations and changes only in DONE.
REQ-024 start sampled high in the same cycle that DONE returns to IDLE is not accepted; acceptance needs ready=1 at the edge.

Reset
REQ-025 rst=1 at a rising edge forces IDLE, out=0, valid=0, ready=1, k=0, partial sums 0.
REQ-026 Reset mid-operation aborts it with no out update and no valid pulse; start is ignored during that reset cycle.
REQ-027 ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 Macro COMPLEX_MULT_PARAM_ACC_EN: when defined, adds port acc and widens P to 2N+1+G.
REQ-029 With the macro, acc=1 makes DONE load out.re+re and out.im+im, wrapping modulo 2^P; acc=0 overwrites.
REQ-030 Without the macro there is no acc port and every operation overwrites out; latency is identical in both builds.

Verification
REQ-031 N=4, a=8'h67 (6+7j), b=8'h53 (5+3j), start one cycle -> after 21 cycles out.re=9, out.im=53, valid one pulse, ready=1.
REQ-032 N=4, a=8'h88 (-8-8j), b=8'h88 -> out.re=0, out.im=128, no overflow.
REQ-033 N=8, a={127,-128}, b={-128,127} -> out.re=0, out.im=32513 after 37 cycles.
REQ-034 start pulsed again mid-operation, then rst asserted at cycle 10 -> first start's result never appears, out=0, ready=1, no valid pulse.
REQ-035 Macro build, N=4: case REQ-031 with acc=0, then again with acc=1 -> out.re=18, out.im=106.
REQ-036 Macro build, N=4, G=4: accumulating 8'h88 x 8'h88 (acc=1) until out.im wraps -> out.im follows im mod 2^13, reinterpreted signed.
